// File: rtl/split_pkg.sv
// Shared types and defaults for the slave-side split handshake (split_slave_if).
package split_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HOLD,
        READY_WAIT,
        DONE_WAIT,
        RESP,
        GUARD_ST
    } split_state_e;

    localparam logic SPLIT_BUSY = 1'b1;
    localparam logic SPLIT_IDLE = 1'b0;

    localparam int DEF_MIN_HOLD = 4;
    localparam int DEF_GUARD    = 3;
    localparam int DEF_TIMEOUT  = 1024;

endpackage

// File: rtl/split_slave_if_sat_counter.sv
// Saturating up-counter with synchronous clear and a terminal-count flag.
module sat_counter #(
    parameter int          WIDTH  = 4,
    parameter int unsigned TC_VAL = 0
) (
    input  logic clk,
    input  logic rstn,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam logic [WIDTH-1:0] TC  = WIDTH'(TC_VAL);
    localparam logic [WIDTH-1:0] MAX = '1;

    logic [WIDTH-1:0] cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != MAX)) begin
            cnt <= cnt + WIDTH'(1);
        end
    end

    assign tc = (cnt == TC);

endmodule

// File: rtl/split_slave_if.sv
// Slave-side end of the split-transaction handshake with the bus arbiter.
// Optional ack-wait timeout is enabled by defining SPLIT_TIMEOUT_EN.
module split_slave_if
    import split_pkg::*;
#(
    parameter int MIN_HOLD = DEF_MIN_HOLD,
    parameter int GUARD    = DEF_GUARD,
    parameter int TIMEOUT  = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic rstn,
    input  logic split_req,
    input  logic data_ready,
    output logic split_out,
    input  logic split_ack,
    output logic resp_active,
    input  logic resp_done,
    output logic split_busy,
    output logic ack_err,
    output logic timeout_err
);

    localparam int   HOLD_W     = (MIN_HOLD < 2) ? 1 : $clog2(MIN_HOLD + 1);
    localparam int   GUARD_W    = (GUARD < 2) ? 1 : $clog2(GUARD + 1);
    localparam int   HOLD_TC    = (MIN_HOLD > 0) ? MIN_HOLD - 1 : 0;
    localparam int   GUARD_TC   = (GUARD > 0) ? GUARD - 1 : 0;
    localparam logic SKIP_GUARD = (GUARD == 0);

    split_state_e state, state_nxt;
    logic         rdy_latch;
    logic         hold_tc;
    logic         guard_tc;
    logic         to_tc;

    logic split_out_nxt;
    logic resp_active_nxt;
    logic split_busy_nxt;
    logic ack_err_nxt;

    sat_counter #(
        .WIDTH  (HOLD_W),
        .TC_VAL (HOLD_TC)
    ) u_hold_cnt (
        .clk  (clk),
        .rstn (rstn),
        .clr  (state != HOLD),
        .en   (state == HOLD),
        .tc   (hold_tc)
    );

    sat_counter #(
        .WIDTH  (GUARD_W),
        .TC_VAL (GUARD_TC)
    ) u_guard_cnt (
        .clk  (clk),
        .rstn (rstn),
        .clr  (state != GUARD_ST),
        .en   (state == GUARD_ST),
        .tc   (guard_tc)
    );

`ifdef SPLIT_TIMEOUT_EN
    sat_counter #(
        .WIDTH  (16),
        .TC_VAL ((TIMEOUT > 0) ? TIMEOUT - 1 : 0)
    ) u_to_cnt (
        .clk  (clk),
        .rstn (rstn),
        .clr  (state != DONE_WAIT),
        .en   (state == DONE_WAIT),
        .tc   (to_tc)
    );

    // A same-cycle ack wins over the timeout.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            timeout_err <= 1'b0;
        end else if ((state == DONE_WAIT) && !split_ack && to_tc) begin
            timeout_err <= 1'b1;
        end
    end
`else
    assign to_tc       = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // Data that shows up early in HOLD must not be lost before the hold ends.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rdy_latch <= 1'b0;
        end else if (state != HOLD) begin
            rdy_latch <= 1'b0;
        end else if (data_ready) begin
            rdy_latch <= 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (split_req) state_nxt = HOLD;
            end
            HOLD: begin
                if (hold_tc) state_nxt = (data_ready || rdy_latch) ? DONE_WAIT : READY_WAIT;
            end
            READY_WAIT: begin
                if (data_ready) state_nxt = DONE_WAIT;
            end
            DONE_WAIT: begin
                if (split_ack)  state_nxt = RESP;
                else if (to_tc) state_nxt = SKIP_GUARD ? IDLE : GUARD_ST;
            end
            RESP: begin
                if (resp_done) state_nxt = SKIP_GUARD ? IDLE : GUARD_ST;
            end
            GUARD_ST: begin
                if (guard_tc) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they land in a register
    // on the same edge as the state itself.
    always_comb begin
        split_out_nxt   = SPLIT_IDLE;
        resp_active_nxt = 1'b0;
        split_busy_nxt  = (state_nxt != IDLE);
        ack_err_nxt     = ack_err;
        if ((state_nxt == HOLD) || (state_nxt == READY_WAIT)) split_out_nxt = SPLIT_BUSY;
        if (state_nxt == RESP) resp_active_nxt = 1'b1;
        if (split_ack && (state != DONE_WAIT)) ack_err_nxt = 1'b1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= IDLE;
            split_out   <= SPLIT_IDLE;
            resp_active <= 1'b0;
            split_busy  <= 1'b0;
            ack_err     <= 1'b0;
        end else begin
            state       <= state_nxt;
            split_out   <= split_out_nxt;
            resp_active <= resp_active_nxt;
            split_busy  <= split_busy_nxt;
            ack_err     <= ack_err_nxt;
        end
    end

endmodule
